pinwheel_bus_arbiter: RTL and testbench
=======================================

// Module: pinwheel_bus_arbiter
// PURPOSE
//  Shares the pinwheel data bus between two TileLink-UL A-channel masters (m0 = core data port,
//  m1 = debug/loader port) and the bus slaves (data_ram, debug_reg, console window).
//  Round-robin arbitration, one outstanding transaction, address decode to a one-hot slave select,
//  D-channel response routed back to the granted master. Sits between pinwheel_core and the slaves.
// PARAMETERS
//  ADDR_MASK     32'hF0000000  mask applied to a_address before tag compare
//  S0_TAG        32'h80000000  data_ram tag
//  S1_TAG        32'hF0000000  debug_reg tag
//  S2_TAG        32'h40000000  console window tag
//  TIMEOUT_CYC   16            WAIT cycles before error response (timeout build only)
// PORTS
//  clock        in   1           single system clock, rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  m0_tla       in   tilelink_a  master 0 request (held until its D beat)
//  m1_tla       in   tilelink_a  master 1 request (held until its D beat)
//  m0_tld       out  tilelink_d  response to master 0
//  m1_tld       out  tilelink_d  response to master 1
//  s_tla        out  tilelink_a  request broadcast to all slaves (a_valid gated by sel)
//  s_sel        out  3           one-hot slave select {s2,s1,s0}
//  s0_tld..s2_tld in tilelink_d  slave responses
//  busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, rr_last=1 (m0 wins first tie), s_sel=0, s_tla.a_valid=0,
//   m*_tld.d_valid=0, m*_tla ready low, busy=0, timeout count=0. Latched request cleared.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; ERR from ISSUE on decode miss.
//  IDLE: if m0.a_valid|m1.a_valid: grant = requester if only one; if both, the one != rr_last.
//   Register grant's A fields; pulse its a_ready for this cycle; -> ISSUE.
//  ISSUE (1 cycle): decode (a_address & ADDR_MASK) vs S0..S2 tags. Hit: s_sel one-hot,
//   s_tla = latched A with a_valid=1 for exactly this cycle; -> WAIT. Miss: s_sel=0 -> ERR.
//  WAIT: s_tla.a_valid=0, s_sel held. When selected slave d_valid=1: that tld forwarded
//   combinationally to granted master same cycle (d_valid=1, other master d_valid=0);
//   rr_last<=grant; -> IDLE. d_valid from unselected slaves ignored.
//  ERR (1 cycle): granted master gets d_valid=1, d_error=1, d_opcode=AccessAckData(1) if latched
//   a_opcode=Get(4) else AccessAck(0), d_data=0, d_source=latched a_source; rr_last<=grant; -> IDLE.
//  Latency: grant->slave A = 1 cycle; block_ram slave -> response 2 cycles after grant edge;
//   back-to-back: new grant earliest cycle after response (IDLE), i.e. 4 cycles/transfer min.
//  Non-granted master's d_valid always 0; m*_tld fields other than d_valid = 'x when invalid.
//  A-channel changes by a master while latched are ignored until next IDLE.
//  Reset mid-transaction: FSM to IDLE immediately; late slave d_valid afterward is dropped.
//  Multiple tag hits impossible by parameter choice; if it occurs, lowest index wins.
// CONFIGURATION
//  PINWHEEL_ARB_TIMEOUT_EN defined: 5-bit-or-wider counter runs in WAIT; on reaching TIMEOUT_CYC
//   without selected d_valid -> ERR (d_error=1); counter clears on WAIT entry.
//  Not defined: no counter; WAIT waits indefinitely for the slave.
// TESTING
//  1 m0 Get 0x80000010 only, data_ram returns 0xDEADBEEF -> m0_tld.d_valid 3rd cycle after
//    request edge, d_data=0xDEADBEEF, d_opcode=1, m1_tld.d_valid=0.
//  2 m0,m1 request together 4 times -> grants m0,m1,m0,m1 (from reset); each gets one d_valid.
//  3 m1 PutFull 0xF0000000 data 0x00000055 -> s_sel=3'b010, s_tla.a_valid one cycle,
//    debug_reg ack routed to m1 with d_opcode=0.
//  4 m0 Get 0x20000000 (unmapped) -> s_sel=0, no slave a_valid, m0 d_valid+d_error=1, d_data=0.
//  5 reset_n low during WAIT, slave responds next cycle -> no d_valid to either master; busy=0.
//  6 TIMEOUT_EN, slave never responds -> d_error=1 exactly TIMEOUT_CYC cycles after WAIT entry;
//    without macro -> busy stays 1, no response after 100 cycles.

Source files
------------

// File: rtl/pinwheel_bus_arbiter.sv
// Two-master round-robin arbiter for the pinwheel TileLink-UL bus: one outstanding transaction, tag decode, D routing.
// Optional build macro PINWHEEL_ARB_TIMEOUT_EN adds a WAIT-state watchdog that answers with d_error.
package pinwheel_bus_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;

  localparam logic [2:0] OP_PUTFULL = 3'd0;
  localparam logic [2:0] OP_GET     = 3'd4;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACKDATA  = 3'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ERR} arb_state_e;
endpackage

// Handshake: a master holds a_valid and its fields until it sees d_valid; a_ready pulses for one
// cycle in IDLE when that master is granted. Slaves accept s_tla whenever a_valid is high.
module pinwheel_bus_arbiter
  import pinwheel_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000,
  parameter logic [31:0] S0_TAG    = 32'h8000_0000,
  parameter logic [31:0] S1_TAG    = 32'hF000_0000,
  parameter logic [31:0] S2_TAG    = 32'h4000_0000
`ifdef PINWHEEL_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  tilelink_a  m0_tla,
  input  tilelink_a  m1_tla,
  output tilelink_d  m0_tld,
  output tilelink_d  m1_tld,
  output logic       m0_a_ready_o,
  output logic       m1_a_ready_o,
  output tilelink_a  s_tla,
  output logic [2:0] s_sel,
  input  tilelink_d  s0_tld,
  input  tilelink_d  s1_tld,
  input  tilelink_d  s2_tld,
  output logic       busy,
  output arb_state_e state_o
);

  arb_state_e state_q;
  logic       grant_q;
  logic       rr_last_q;
  tilelink_a  a_q;
  logic [2:0] sel_q;
  logic       s_valid_q;

  logic       grant_d;
  tilelink_a  win_a;
  logic [2:0] win_sel;
  tilelink_d  slave_d;
  logic       resp_hit;
  tilelink_d  rsp;

`ifdef PINWHEEL_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [CNT_W-1:0] cnt_q;
`endif

  // Lowest index wins if tags ever overlap.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [31:0] t;
    t = addr & ADDR_MASK;
    if (t == S0_TAG)      decode = 3'b001;
    else if (t == S1_TAG) decode = 3'b010;
    else if (t == S2_TAG) decode = 3'b100;
    else                  decode = 3'b000;
  endfunction

  always_comb begin
    grant_d  = (m0_tla.a_valid && m1_tla.a_valid) ? ~rr_last_q : m1_tla.a_valid;
    win_a    = grant_d ? m1_tla : m0_tla;
    win_sel  = decode(win_a.a_address);
    m0_a_ready_o = (state_q == ST_IDLE) && m0_tla.a_valid && !grant_d;
    m1_a_ready_o = (state_q == ST_IDLE) && m1_tla.a_valid &&  grant_d;

    slave_d  = sel_q[0] ? s0_tld : (sel_q[1] ? s1_tld : s2_tld);
    resp_hit = (state_q == ST_WAIT) &&
               |(sel_q & {s2_tld.d_valid, s1_tld.d_valid, s0_tld.d_valid});

    rsp = '0;
    if (resp_hit) begin
      rsp = slave_d;
    end else if (state_q == ST_ERR) begin
      rsp.d_valid  = 1'b1;
      rsp.d_error  = 1'b1;
      rsp.d_opcode = (a_q.a_opcode == OP_GET) ? D_ACKDATA : D_ACK;
      rsp.d_source = a_q.a_source;
      rsp.d_size   = a_q.a_size;
    end
    m0_tld = rsp;
    m1_tld = rsp;
    m0_tld.d_valid = rsp.d_valid && !grant_q;
    m1_tld.d_valid = rsp.d_valid &&  grant_q;

    s_tla = a_q;
    s_tla.a_valid = s_valid_q;
  end

  assign s_sel   = sel_q;
  assign busy    = (state_q != ST_IDLE);
  assign state_o = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      a_q       <= '0;
      sel_q     <= 3'b000;
      s_valid_q <= 1'b0;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_tla.a_valid || m1_tla.a_valid) begin
            grant_q   <= grant_d;
            a_q       <= win_a;
            sel_q     <= win_sel;
            s_valid_q <= |win_sel;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          s_valid_q <= 1'b0;
`ifdef PINWHEEL_ARB_TIMEOUT_EN
          cnt_q     <= '0;
`endif
          state_q   <= (|sel_q) ? ST_WAIT : ST_ERR;
        end
        ST_WAIT: begin
          if (resp_hit) begin
            rr_last_q <= grant_q;
            sel_q     <= 3'b000;
            state_q   <= ST_IDLE;
          end
`ifdef PINWHEEL_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            sel_q   <= 3'b000;
            state_q <= ST_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_ERR: begin
          rr_last_q <= grant_q;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pinwheel_bus_arbiter.sv
// Directed bench for pinwheel_bus_arbiter: behavioural slaves with per-slave latency, hand-computed expectations.
module tb_pinwheel_bus_arbiter;
  import pinwheel_bus_pkg::*;

  logic       clock;
  logic       reset_n;
  tilelink_a  m0_tla, m1_tla, s_tla;
  tilelink_d  m0_tld, m1_tld;
  tilelink_d  s_tld [3];
  logic       m0_a_ready_o, m1_a_ready_o;
  logic [2:0] s_sel;
  logic       busy;
  arb_state_e state_o;

  int n_cmp;
  int n_bad;

  int          s_lat   [3] = '{2, 1, 1};
  int          pend    [3] = '{0, 0, 0};
  logic [31:0] s_rdata [3] = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'h0000_0000};
  logic [2:0]  cap_op  [3];
  logic [3:0]  cap_src [3];

  pinwheel_bus_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .m0_tla       (m0_tla),
    .m1_tla       (m1_tla),
    .m0_tld       (m0_tld),
    .m1_tld       (m1_tld),
    .m0_a_ready_o (m0_a_ready_o),
    .m1_a_ready_o (m1_a_ready_o),
    .s_tla        (s_tla),
    .s_sel        (s_sel),
    .s0_tld       (s_tld[0]),
    .s1_tld       (s_tld[1]),
    .s2_tld       (s_tld[2]),
    .busy         (busy),
    .state_o      (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave k answers s_lat[k] cycles after it sees its select with a_valid; s_lat 0 = never answers.
  initial for (int k = 0; k < 3; k++) s_tld[k] = '0;
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      s_tld[k] = '0;
      if (pend[k] > 0) begin
        pend[k] = pend[k] - 1;
        if (pend[k] == 0) begin
          s_tld[k].d_valid  = 1'b1;
          s_tld[k].d_opcode = (cap_op[k] == OP_GET) ? D_ACKDATA : D_ACK;
          s_tld[k].d_source = cap_src[k];
          s_tld[k].d_size   = 3'd2;
          s_tld[k].d_data   = (cap_op[k] == OP_GET) ? s_rdata[k] : 32'h0;
        end
      end
      if (s_tla.a_valid && s_sel[k] && s_lat[k] > 0) begin
        pend[k]    = s_lat[k];
        cap_op[k]  = s_tla.a_opcode;
        cap_src[k] = s_tla.a_source;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic do_reset();
    m0_tla  = '0;
    m1_tla  = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  function automatic tilelink_a mk_req(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] src);
    tilelink_a r;
    r           = '0;
    r.a_valid   = 1'b1;
    r.a_opcode  = op;
    r.a_size    = 3'd2;
    r.a_source  = src;
    r.a_address = addr;
    r.a_mask    = 4'hF;
    r.a_data    = data;
    return r;
  endfunction

  initial begin
    logic g;
    logic [3:0] exp_grant;
    int hit_idx;
    int seen;
    n_cmp = 0;
    n_bad = 0;
    m0_tla  = '0;
    m1_tla  = '0;
    reset_n = 1'b0;
    step();
    step();
    check("rst_state",  state_o, ST_IDLE);
    check("rst_busy",   busy, 0);
    check("rst_sel",    s_sel, 0);
    check("rst_savld",  s_tla.a_valid, 0);
    check("rst_m0dv",   m0_tld.d_valid, 0);
    check("rst_m1dv",   m1_tld.d_valid, 0);
    check("rst_ready",  {m1_a_ready_o, m0_a_ready_o}, 0);
    reset_n = 1'b1;
    step();

    // 1: m0 Get to data_ram
    m0_tla = mk_req(OP_GET, 32'h8000_0010, 32'h0, 4'd3);
    #1;
    check("t1_rdy0", m0_a_ready_o, 1);
    check("t1_rdy1", m1_a_ready_o, 0);
    check("t1_busy_idle", busy, 0);
    step();
    check("t1_state_issue", state_o, ST_ISSUE);
    check("t1_sel", s_sel, 3'b001);
    check("t1_savld", s_tla.a_valid, 1);
    check("t1_saddr", s_tla.a_address, 32'h8000_0010);
    check("t1_busy", busy, 1);
    step();
    check("t1_early_dv", m0_tld.d_valid, 0);
    check("t1_savld_wait", s_tla.a_valid, 0);
    check("t1_sel_held", s_sel, 3'b001);
    step();
    check("t1_m0dv", m0_tld.d_valid, 1);
    check("t1_data", m0_tld.d_data, 32'hDEAD_BEEF);
    check("t1_op", m0_tld.d_opcode, D_ACKDATA);
    check("t1_src", m0_tld.d_source, 4'd3);
    check("t1_m1dv", m1_tld.d_valid, 0);
    m0_tla = '0;
    step();
    check("t1_state_end", state_o, ST_IDLE);
    check("t1_busy_end", busy, 0);

    // 2: both masters request continuously from reset -> m0, m1, m0, m1
    do_reset();
    exp_grant = 4'b1010;
    m0_tla = mk_req(OP_GET, 32'h8000_0000, 32'h0, 4'd1);
    m1_tla = mk_req(OP_GET, 32'h8000_0004, 32'h0, 4'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = exp_grant[k];
      check("t2_rdy0", m0_a_ready_o, !g);
      check("t2_rdy1", m1_a_ready_o, g);
      step();
      step();
      step();
      check("t2_m0dv", m0_tld.d_valid, !g);
      check("t2_m1dv", m1_tld.d_valid, g);
      check("t2_src", g ? m1_tld.d_source : m0_tld.d_source, g ? 4'd2 : 4'd1);
      if (k == 3) begin
        m0_tla = '0;
        m1_tla = '0;
      end
      step();
    end
    check("t2_busy_end", busy, 0);

    // 3: m1 PutFull to debug_reg
    m1_tla = mk_req(OP_PUTFULL, 32'hF000_0000, 32'h0000_0055, 4'd5);
    #1;
    check("t3_rdy1", m1_a_ready_o, 1);
    step();
    check("t3_sel", s_sel, 3'b010);
    check("t3_savld", s_tla.a_valid, 1);
    check("t3_sdata", s_tla.a_data, 32'h0000_0055);
    check("t3_sop", s_tla.a_opcode, OP_PUTFULL);
    step();
    check("t3_savld_off", s_tla.a_valid, 0);
    check("t3_sel_held", s_sel, 3'b010);
    check("t3_m1dv", m1_tld.d_valid, 1);
    check("t3_op", m1_tld.d_opcode, D_ACK);
    check("t3_src", m1_tld.d_source, 4'd5);
    check("t3_err", m1_tld.d_error, 0);
    check("t3_m0dv", m0_tld.d_valid, 0);
    m1_tla = '0;
    step();

    // 4: decode miss -> error response
    m0_tla = mk_req(OP_GET, 32'h2000_0000, 32'h0, 4'd7);
    step();
    check("t4_state_issue", state_o, ST_ISSUE);
    check("t4_sel", s_sel, 3'b000);
    check("t4_savld", s_tla.a_valid, 0);
    step();
    check("t4_state_err", state_o, ST_ERR);
    check("t4_m0dv", m0_tld.d_valid, 1);
    check("t4_err", m0_tld.d_error, 1);
    check("t4_data", m0_tld.d_data, 32'h0);
    check("t4_op", m0_tld.d_opcode, D_ACKDATA);
    check("t4_src", m0_tld.d_source, 4'd7);
    check("t4_m1dv", m1_tld.d_valid, 0);
    check("t4_savld_err", s_tla.a_valid, 0);
    m0_tla = '0;
    step();
    check("t4_busy_end", busy, 0);
    m1_tla = mk_req(OP_PUTFULL, 32'h0000_0100, 32'h1234, 4'd9);
    step();
    step();
    check("t4b_m1dv", m1_tld.d_valid, 1);
    check("t4b_err", m1_tld.d_error, 1);
    check("t4b_op", m1_tld.d_opcode, D_ACK);
    m1_tla = '0;
    step();

    // 5: reset while waiting on data_ram; its late response must be dropped
    m0_tla = mk_req(OP_GET, 32'h8000_0020, 32'h0, 4'd4);
    step();
    step();
    check("t5_state_wait", state_o, ST_WAIT);
    reset_n = 1'b0;
    m0_tla  = '0;
    #1;
    check("t5_busy_rst", busy, 0);
    step();
    reset_n = 1'b1;
    #1;
    check("t5_m0dv", m0_tld.d_valid, 0);
    check("t5_m1dv", m1_tld.d_valid, 0);
    check("t5_busy", busy, 0);
    step();
    check("t5_busy_after", busy, 0);
    check("t5_m0dv_after", m0_tld.d_valid, 0);

    // 6: debug_reg never answers
    s_lat[1] = 0;
    m0_tla = mk_req(OP_GET, 32'hF000_0010, 32'h0, 4'd6);
    step();
    step();
`ifdef PINWHEEL_ARB_TIMEOUT_EN
    hit_idx = -1;
    for (int i = 0; i < 40 && hit_idx < 0; i++) begin
      if (m0_tld.d_valid) hit_idx = i;
      else step();
    end
    check("t6_timeout_cyc", hit_idx, 16);
    check("t6_err", m0_tld.d_error, 1);
    check("t6_op", m0_tld.d_opcode, D_ACKDATA);
    check("t6_src", m0_tld.d_source, 4'd6);
    m0_tla = '0;
    step();
    check("t6_busy_end", busy, 0);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (m0_tld.d_valid || m1_tld.d_valid) seen++;
      step();
    end
    check("t6_no_resp", seen, 0);
    check("t6_busy", busy, 1);
    check("t6_state", state_o, ST_WAIT);
    do_reset();
    check("t6_busy_rst", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
